// File: rtl/jtdsp16_xaau_stk.sv
// Program-address unit for the JTDSP16 core: pc sequencing, pt/pi pointers,
// circular return stack, hardware repeat and single-level interrupt shadow.
module jtdsp16_xaau_stk #(
  parameter  int AW    = 16,
  parameter  int IW    = 12,
  parameter  int DEPTH = 4,
  parameter  int RW    = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int SW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          goto_ja,
  input  logic          call_ja,
  input  logic          goto_pt,
  input  logic          call_pt,
  input  logic          ret,
  input  logic          iret,
  input  logic [IW-1:0] i_field,
  input  logic          load_pt,
  input  logic          load_pi,
  input  logic          load_i,
  input  logic          post_inc,
  input  logic [AW-1:0] load_data,
  input  logic          rep_load,
  input  logic [RW-1:0] rep_cnt,
  input  logic          pc_halt,
  input  logic          ext_irq,
  input  logic          clr_flags,
  output logic [AW-1:0] rom_addr,
  output logic [AW-1:0] pt,
  output logic [AW-1:0] pi,
  output logic [AW-1:0] stk_top,
  output logic [SW-1:0] sp,
  output logic          stk_ovf,
  output logic          stk_unf,
  output logic          shadow,
  output logic          irq_ack,
  output logic          rep_busy
);

  logic        [AW-1:0] pc, pc_inc, pc_next, jmp_ja;
  logic        [AW-1:0] pt_next, pi_next;
  logic signed [AW-1:0] i_ext;
  logic        [IW-1:0] i_reg;
  logic        [AW-1:0] stack [DEPTH];
  logic        [PW-1:0] wr_ptr;
  logic        [RW-1:0] rep_left, rep_next;
  logic                 irq_take, flow, hold, do_push, do_pop;
  logic                 ovf_set, unf_set, busy_next;

  assign rom_addr = pc;
  assign stk_top  = (sp == '0) ? '0 : stack[wr_ptr - PW'(1)];
  assign pc_inc   = pc + AW'(1);
  assign jmp_ja   = {pc[AW-1:IW], i_field};
  assign i_ext    = {{(AW-IW){i_reg[IW-1]}}, i_reg};
  assign irq_take = ext_irq && !shadow && !rep_busy;
  assign ovf_set  = do_push && (sp == SW'(DEPTH));

  always_comb begin
    pc_next = pc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    unf_set = 1'b0;
    flow    = 1'b1;
    hold    = 1'b0;
    if (irq_take) begin
      pc_next = '0;
    end else if (iret) begin
      pc_next = pi;
    end else if (ret) begin
      if (sp != '0) begin
        pc_next = stk_top;
        do_pop  = 1'b1;
      end else begin
        pc_next = '0;
        unf_set = 1'b1;
      end
    end else if (call_pt) begin
      pc_next = pt;
      do_push = 1'b1;
    end else if (call_ja) begin
      pc_next = jmp_ja;
      do_push = 1'b1;
    end else if (goto_pt) begin
      pc_next = pt;
    end else if (goto_ja) begin
      pc_next = jmp_ja;
    end else begin
      flow = 1'b0;
      if (!rep_load && rep_left != '0) hold = 1'b1;
      else if (!pc_halt)                pc_next = pc_inc;
    end
  end

  // rep_busy stays up through the final pass of the repeated instruction so an
  // interrupt is only taken once the instruction after the repeat is fetched.
  always_comb begin
    rep_next = '0;
    if (!flow) begin
      if (rep_load)             rep_next = rep_cnt;
      else if (rep_left != '0) rep_next = rep_left - RW'(1);
    end
    busy_next = (rep_next != '0) || hold;
  end

  always_comb begin
    pt_next = pt;
    if (load_pt)       pt_next = load_data;
    else if (post_inc) pt_next = pt + i_ext;
    pi_next = pi;
    if (irq_take)     pi_next = pc;
    else if (load_pi) pi_next = load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      pt       <= '0;
      pi       <= '0;
      i_reg    <= '0;
      sp       <= '0;
      wr_ptr   <= '0;
      rep_left <= '0;
      rep_busy <= 1'b0;
      shadow   <= 1'b0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
      irq_ack  <= 1'b0;
    end else if (cen) begin
      pc       <= pc_next;
      pt       <= pt_next;
      pi       <= pi_next;
      if (load_i) i_reg <= load_data[IW-1:0];
      rep_left <= rep_next;
      rep_busy <= busy_next;
      irq_ack  <= irq_take;
      if (irq_take)  shadow <= 1'b1;
      else if (iret) shadow <= 1'b0;
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (!ovf_set) sp <= sp + SW'(1);
      end else if (do_pop) begin
        wr_ptr <= wr_ptr - PW'(1);
        sp     <= sp - SW'(1);
      end
      if (ovf_set)        stk_ovf <= 1'b1;
      else if (clr_flags) stk_ovf <= 1'b0;
      if (unf_set)        stk_unf <= 1'b1;
      else if (clr_flags) stk_unf <= 1'b0;
    end
  end

  // A push with the stack full lands on the oldest slot, giving circular discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stack[k] <= '0;
    end else if (cen && do_push) begin
      stack[wr_ptr] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_jtdsp16_xaau_stk.sv
// Bench for jtdsp16_xaau_stk: directed vector table, hand sequences for repeat/IRQ
// corners, then random traffic against a queue-based reference model.
module tb_jtdsp16_xaau_stk;
  localparam int AW = 16, IW = 12, DEPTH = 4, RW = 8;

  logic clk = 1'b0;
  logic rst, cen, goto_ja, call_ja, goto_pt, call_pt, ret, iret;
  logic load_pt, load_pi, load_i, post_inc, rep_load, pc_halt, ext_irq, clr_flags;
  logic [IW-1:0] i_field;
  logic [AW-1:0] load_data;
  logic [RW-1:0] rep_cnt;
  logic [AW-1:0] rom_addr, pt, pi, stk_top;
  logic [2:0]    sp;
  logic          stk_ovf, stk_unf, shadow, irq_ack, rep_busy;

  jtdsp16_xaau_stk #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .goto_ja(goto_ja), .call_ja(call_ja),
    .goto_pt(goto_pt), .call_pt(call_pt), .ret(ret), .iret(iret), .i_field(i_field),
    .load_pt(load_pt), .load_pi(load_pi), .load_i(load_i), .post_inc(post_inc),
    .load_data(load_data), .rep_load(rep_load), .rep_cnt(rep_cnt), .pc_halt(pc_halt),
    .ext_irq(ext_irq), .clr_flags(clr_flags), .rom_addr(rom_addr), .pt(pt), .pi(pi),
    .stk_top(stk_top), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .shadow(shadow),
    .irq_ack(irq_ack), .rep_busy(rep_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: program flow described directly from the instruction rules.
  logic [15:0] m_pc, m_pt, m_pi;
  logic [11:0] m_i;
  logic [7:0]  m_rep;
  bit          m_sh, m_ovf, m_unf, m_ack, m_busy;
  logic [15:0] stk[$];

  function automatic void model_reset();
    m_pc = 0; m_pt = 0; m_pi = 0; m_i = 0; m_rep = 0;
    m_sh = 0; m_ovf = 0; m_unf = 0; m_ack = 0; m_busy = 0;
    stk.delete();
  endfunction

  function automatic bit push(input logic [15:0] v);
    stk.push_back(v);
    if (stk.size() > DEPTH) begin
      void'(stk.pop_front());
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_step();
    logic [15:0] npc, seq;
    logic [7:0]  nrep;
    bit take, hold, ovf_s, unf_s;
    if (!cen) return;
    take = ext_irq && !m_sh && !m_busy;
    hold = 0; ovf_s = 0; unf_s = 0; nrep = 8'd0;
    seq = pc_halt ? m_pc : m_pc + 16'd1;
    npc = m_pc;
    if (take) npc = 16'd0;
    else if (iret) npc = m_pi;
    else if (ret) begin
      if (stk.size() != 0) npc = stk.pop_back();
      else begin npc = 16'd0; unf_s = 1; end
    end
    else if (call_pt) begin ovf_s = push(m_pc + 16'd1); npc = m_pt; end
    else if (call_ja) begin ovf_s = push(m_pc + 16'd1); npc = {m_pc[15:12], i_field}; end
    else if (goto_pt) npc = m_pt;
    else if (goto_ja) npc = {m_pc[15:12], i_field};
    else if (rep_load) begin nrep = rep_cnt; npc = seq; end
    else if (m_rep != 0) begin hold = 1; nrep = m_rep - 8'd1; end
    else npc = seq;
    if (load_pt) m_pt = load_data;
    else if (post_inc) m_pt = m_pt + {{4{m_i[11]}}, m_i};
    if (take) m_pi = m_pc;
    else if (load_pi) m_pi = load_data;
    if (load_i) m_i = load_data[11:0];
    if (take) m_sh = 1;
    else if (iret) m_sh = 0;
    m_ovf = ovf_s ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    m_unf = unf_s ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
    m_ack  = take;
    m_busy = (nrep != 0) || hold;
    m_rep  = nrep;
    m_pc   = npc;
  endfunction

  task automatic chk_model(input string tag);
    logic [15:0] t;
    t = (stk.size() != 0) ? stk[$] : 16'h0;
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(m_pc));
    chk({tag, " pt"},       32'(pt),       32'(m_pt));
    chk({tag, " pi"},       32'(pi),       32'(m_pi));
    chk({tag, " sp"},       32'(sp),       32'(stk.size()));
    chk({tag, " stk_top"},  32'(stk_top),  32'(t));
    chk({tag, " flags"},    32'({stk_ovf, stk_unf, shadow, irq_ack, rep_busy}),
                            32'({m_ovf, m_unf, m_sh, m_ack, m_busy}));
  endtask

  task automatic idle();
    cen = 1; goto_ja = 0; call_ja = 0; goto_pt = 0; call_pt = 0; ret = 0; iret = 0;
    load_pt = 0; load_pi = 0; load_i = 0; post_inc = 0; rep_load = 0; pc_halt = 0;
    ext_irq = 0; clr_flags = 0; i_field = '0; load_data = '0; rep_cnt = '0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef enum int {NOP, LDPT, GOTOPT, CALLJA, CALLPTLD, RET, CLR} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] arg;
    logic [15:0] pc;
    int          sp;
    logic [15:0] top;
    logic        ovf;
    logic        unf;
  } vec_t;
  vec_t tbl[15];

  task automatic apply_op(input op_e op, input logic [15:0] arg);
    idle();
    case (op)
      LDPT:     begin load_pt = 1; load_data = arg; end
      GOTOPT:   goto_pt = 1;
      CALLJA:   begin call_ja = 1; i_field = arg[11:0]; end
      CALLPTLD: begin call_pt = 1; load_pt = 1; load_data = arg; end
      RET:      ret = 1;
      CLR:      clr_flags = 1;
      default:  ;
    endcase
    cyc();
  endtask

  initial begin
    tbl[0]  = '{LDPT,     16'h3005, 16'h0001, 0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{GOTOPT,   16'h0000, 16'h3005, 0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{CALLJA,   16'h0123, 16'h3123, 1, 16'h3006, 1'b0, 1'b0};
    tbl[3]  = '{RET,      16'h0000, 16'h3006, 0, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{CALLPTLD, 16'h4000, 16'h3005, 1, 16'h3007, 1'b0, 1'b0};
    tbl[5]  = '{CALLPTLD, 16'h5000, 16'h4000, 2, 16'h3006, 1'b0, 1'b0};
    tbl[6]  = '{CALLPTLD, 16'h6000, 16'h5000, 3, 16'h4001, 1'b0, 1'b0};
    tbl[7]  = '{CALLPTLD, 16'h7000, 16'h6000, 4, 16'h5001, 1'b0, 1'b0};
    tbl[8]  = '{CALLPTLD, 16'h8000, 16'h7000, 4, 16'h6001, 1'b1, 1'b0};
    tbl[9]  = '{RET,      16'h0000, 16'h6001, 3, 16'h5001, 1'b1, 1'b0};
    tbl[10] = '{RET,      16'h0000, 16'h5001, 2, 16'h4001, 1'b1, 1'b0};
    tbl[11] = '{RET,      16'h0000, 16'h4001, 1, 16'h3006, 1'b1, 1'b0};
    tbl[12] = '{RET,      16'h0000, 16'h3006, 0, 16'h0000, 1'b1, 1'b0};
    tbl[13] = '{RET,      16'h0000, 16'h0000, 0, 16'h0000, 1'b1, 1'b1};
    tbl[14] = '{CLR,      16'h0000, 16'h0001, 0, 16'h0000, 1'b0, 1'b0};

    // reset state and free-running count
    do_reset();
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset pt/pi", 32'({pt, pi}), 32'h0);
    chk("reset sp/top", 32'({sp, stk_top}), 32'h0);
    chk("reset flags", 32'({stk_ovf, stk_unf, shadow, irq_ack, rep_busy}), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("count %0d", k), 32'(rom_addr), 32'(k));
    end

    // call/return and overflow/underflow table
    do_reset();
    for (int k = 0; k < 15; k++) begin
      apply_op(tbl[k].op, tbl[k].arg);
      chk($sformatf("vec%0d pc", k), 32'(rom_addr), 32'(tbl[k].pc));
      chk($sformatf("vec%0d sp", k), 32'(sp), 32'(tbl[k].sp));
      chk($sformatf("vec%0d top", k), 32'(stk_top), 32'(tbl[k].top));
      chk($sformatf("vec%0d ovf/unf", k), 32'({stk_ovf, stk_unf}), 32'({tbl[k].ovf, tbl[k].unf}));
    end

    // clock enable low freezes everything
    do_reset();
    cen = 0; call_ja = 1; i_field = 12'h055;
    cyc();
    chk("cen low pc", 32'(rom_addr), 32'h0);
    chk("cen low sp", 32'(sp), 32'h0);
    cen = 1;
    cyc();
    chk("cen high call pc", 32'(rom_addr), 32'h0055);
    chk("cen high call top", 32'(stk_top), 32'h0001);

    // post-increment with negative index, load_pt priority
    do_reset();
    load_i = 1; load_data = 16'h0FFF;
    cyc();
    idle(); post_inc = 1;
    cyc();
    chk("post_inc -1", 32'(pt), 32'hFFFF);
    load_pt = 1; load_data = 16'h1234;
    cyc();
    chk("load_pt wins", 32'(pt), 32'h1234);
    load_pt = 0;
    cyc();
    chk("post_inc again", 32'(pt), 32'h1233);

    // repeat with zero count does not hold
    do_reset();
    rep_load = 1; rep_cnt = 8'd0;
    cyc();
    chk("rep0 busy", 32'(rep_busy), 32'h0);
    idle();
    cyc();
    chk("rep0 advance", 32'(rom_addr), 32'h2);

    // repeat hold with deferred interrupt, then shadow and iret
    do_reset();
    load_pt = 1; load_data = 16'h0010;
    cyc();
    idle(); goto_pt = 1;
    cyc();
    idle(); rep_load = 1; rep_cnt = 8'd3;
    cyc();
    chk("rep load pc", 32'(rom_addr), 32'h11);
    chk("rep load busy", 32'(rep_busy), 32'h1);
    idle(); ext_irq = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("rep hold %0d pc", k), 32'(rom_addr), 32'h11);
      chk($sformatf("rep hold %0d ack", k), 32'(irq_ack), 32'h0);
    end
    cyc();
    chk("rep end pc", 32'(rom_addr), 32'h12);
    chk("rep end ack/busy", 32'({irq_ack, rep_busy}), 32'h0);
    cyc();
    chk("irq entry pc", 32'(rom_addr), 32'h0);
    chk("irq entry pi", 32'(pi), 32'h12);
    chk("irq entry ack/shadow", 32'({irq_ack, shadow}), 32'h3);
    cyc();
    chk("nested irq ignored pc", 32'(rom_addr), 32'h1);
    chk("nested irq ack/shadow", 32'({irq_ack, shadow}), 32'h1);
    iret = 1;
    cyc();
    chk("iret pc", 32'(rom_addr), 32'h12);
    chk("iret shadow", 32'({irq_ack, shadow}), 32'h0);
    iret = 0;
    cyc();
    chk("re-entry pc", 32'(rom_addr), 32'h0);
    chk("re-entry ack/shadow", 32'({irq_ack, shadow}), 32'h3);
    ext_irq = 0; iret = 1;
    cyc();
    chk("second iret pc", 32'(rom_addr), 32'h12);

    // asynchronous reset in the middle of a repeat
    do_reset();
    rep_load = 1; rep_cnt = 8'd5;
    cyc();
    idle();
    cyc();
    chk("mid-rep busy", 32'({rom_addr, rep_busy}), 32'h00003);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("async rst", 32'({rom_addr, rep_busy}), 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    cyc();
    chk("after rst pc", 32'({rom_addr, rep_busy}), 32'h00002);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      cen       = ($urandom_range(0, 9) != 0);
      goto_ja   = ($urandom_range(0, 15) == 0);
      call_ja   = ($urandom_range(0, 12) == 0);
      goto_pt   = ($urandom_range(0, 15) == 0);
      call_pt   = ($urandom_range(0, 12) == 0);
      ret       = ($urandom_range(0, 8) == 0);
      iret      = ($urandom_range(0, 20) == 0);
      load_pt   = ($urandom_range(0, 10) == 0);
      load_pi   = ($urandom_range(0, 12) == 0);
      load_i    = ($urandom_range(0, 12) == 0);
      post_inc  = ($urandom_range(0, 5) == 0);
      rep_load  = ($urandom_range(0, 11) == 0);
      rep_cnt   = 8'($urandom_range(0, 4));
      pc_halt   = ($urandom_range(0, 9) == 0);
      clr_flags = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) ext_irq = ~ext_irq;
      i_field   = 12'($urandom);
      load_data = 16'($urandom);
      cyc();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
